// File: rtl/sram_wbe_ctrl_pkg.sv
// Shared types and helpers for the sram_wbe_ctrl RAM front end.
// Holds the controller state enum and the byte-offset width calculation.
package sram_wbe_ctrl_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    // Number of byte-offset bits in a byte address for a given word width.
    function automatic int off_bits(input int dwidth);
        return $clog2(dwidth / 8);
    endfunction

endpackage

// File: rtl/sram_wbe_ctrl_if.sv
// Valid/ready request and response bundle for sram_wbe_ctrl.
// master: requester side (LSU/bridge); slave: the controller.
interface sram_wbe_ctrl_if #(
    parameter int DWIDTH = 32
);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [DWIDTH/8-1:0]   req_wstrb;
    logic [DWIDTH-1:0]     req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DWIDTH-1:0]     resp_rdata;
    logic                  resp_err;

    modport master (
        output req_valid, req_we, req_addr,
        output req_wstrb, req_wdata, resp_ready,
        input  req_ready, resp_valid,
        input  resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr,
        input  req_wstrb, req_wdata, resp_ready,
        output req_ready, resp_valid,
        output resp_rdata, resp_err
    );

endinterface

// File: rtl/sram_wbe_ctrl_ram.sv
// Single-port synchronous-read RAM with byte write enables (read-first).
// Ports: clk, en, wbe (byte enables), addr (word), d (write data), q (read reg).
module SYNC_RAM_WBE #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
) (
    input  logic                clk,
    input  logic                en,
    input  logic [DWIDTH/8-1:0] wbe,
    input  logic [AWIDTH-1:0]   addr,
    input  logic [DWIDTH-1:0]   d,
    output logic [DWIDTH-1:0]   q
);

    localparam int DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];

    // q only updates when enabled, so it holds the last read while idle.
    always_ff @(posedge clk) begin
        if (en) begin
            q <= mem[addr];
            for (int b = 0; b < DWIDTH / 8; b++) begin
                if (wbe[b]) begin
                    mem[addr][b*8 +: 8] <= d[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/sram_wbe_ctrl.sv
// Request/response front end for one byte-enable data RAM with reset scrub.
// Ports: clk, rst_n, bus (slave side of sram_wbe_ctrl_if), init_done.
module sram_wbe_ctrl
    import sram_wbe_ctrl_pkg::*;
#(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_wbe_ctrl_if.slave       bus,
    output logic                 init_done
);

    localparam int OFF = off_bits(DWIDTH);
    localparam int NB  = DWIDTH / 8;

    state_t              state;
    logic [AWIDTH-1:0]   cnt;
    logic                resp_valid;
    logic                err_q;
    logic                acc;
    logic                bad;
    logic                lo_bad;
    logic                hi_bad;

    logic                ram_en;
    logic [NB-1:0]       ram_wbe;
    logic [AWIDTH-1:0]   ram_addr;
    logic [DWIDTH-1:0]   ram_d;
    logic [DWIDTH-1:0]   ram_q;

    // Misaligned byte offset; absent when words are a single byte.
    if (OFF > 0) begin : g_lo
        assign lo_bad = |bus.req_addr[OFF-1:0];
    end else begin : g_lo_none
        assign lo_bad = 1'b0;
    end

    // Address bits above the array are out of range.
    if (AWIDTH + OFF < 32) begin : g_hi
        assign hi_bad = |bus.req_addr[31:AWIDTH+OFF];
    end else begin : g_hi_none
        assign hi_bad = 1'b0;
    end

    assign bad       = lo_bad | hi_bad;
    assign init_done = (state == RUN);

    assign bus.req_ready = (state == RUN) &&
                           (!resp_valid || bus.resp_ready);
    assign acc = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR_ON_RESET ? INIT : RUN;
            cnt   <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
            if (&cnt) begin
                state <= RUN;
            end
        end
    end

    always_comb begin
        ram_en   = 1'b0;
        ram_wbe  = '0;
        ram_addr = cnt;
        ram_d    = '0;
        if (state == INIT) begin
            ram_en  = 1'b1;
            ram_wbe = '1;
        end else if (acc && !bad) begin
            ram_en   = 1'b1;
            ram_addr = bus.req_addr[AWIDTH+OFF-1:OFF];
            ram_wbe  = bus.req_we ? bus.req_wstrb : '0;
            ram_d    = bus.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            err_q      <= 1'b0;
        end else if (acc) begin
            resp_valid <= 1'b1;
            err_q      <= bad;
        end else if (resp_valid && bus.resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    // The RAM output register doubles as the response buffer: it is
    // not enabled again until a new request is accepted.
    assign bus.resp_valid = resp_valid;
    assign bus.resp_err   = resp_valid && err_q;
    assign bus.resp_rdata = (resp_valid && !err_q) ? ram_q : '0;

    SYNC_RAM_WBE #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk  (clk),
        .en   (ram_en),
        .wbe  (ram_wbe),
        .addr (ram_addr),
        .d    (ram_d),
        .q    (ram_q)
    );

endmodule

// File: tb/tb_sram_wbe_ctrl.sv
// Directed self-checking bench for sram_wbe_ctrl (DWIDTH=32, AWIDTH=4).
// Covers scrub, byte-enable writes, streaming, backpressure, errors, reset.
module tb_sram_wbe_ctrl;

    logic clk;
    logic rst_n;
    logic init_done;
    int   total;
    int   passed;
    int   failed;
    int   n;
    logic rdy_seen;
    logic [31:0] rd;
    logic        er;

    sram_wbe_ctrl_if #(.DWIDTH(32)) bus ();

    sram_wbe_ctrl #(
        .DWIDTH         (32),
        .AWIDTH         (4),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .init_done (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        chk({tag, "_err"}, {31'd0, bus.resp_err}, 32'd0);
        chk({tag, "_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd0);
        chk({tag, "_done"}, {31'd0, init_done}, 32'd0);
    endtask

    // Counts posedges from a release at negedge until init_done.
    task automatic wait_init(output int edges, output logic rdy);
        edges = 0;
        rdy   = 1'b0;
        while (!init_done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (!init_done && bus.req_ready) rdy = 1'b1;
        end
    endtask

    task automatic xact(input logic we,
                        input logic [31:0] addr,
                        input logic [3:0] st,
                        input logic [31:0] wd,
                        output logic [31:0] rdo,
                        output logic ero);
        int k;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wstrb  = st;
        bus.req_wdata  = wd;
        bus.resp_ready = 1'b1;
        k = 0;
        while (!bus.req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("xact_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("xact_valid", {31'd0, bus.resp_valid}, 32'd1);
        rdo = bus.resp_rdata;
        ero = bus.resp_err;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wstrb  = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;

        // Reset values and scrub timing.
        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        wait_init(n, rdy_seen);
        chk("scrub_edges", n, 32'd16);
        chk("scrub_ready0", {31'd0, rdy_seen}, 32'd0);

        // Every word reads back zero after the scrub.
        for (int i = 0; i < 16; i++) begin
            xact(1'b0, i * 4, 4'h0, 32'h0, rd, er);
            chk("scrub_rd", rd, 32'h0);
            chk("scrub_err", {31'd0, er}, 32'd0);
        end

        // Read-first writes and byte strobes.
        xact(1'b1, 32'h8, 4'hF, 32'hDEADBEEF, rd, er);
        chk("wr1_old", rd, 32'h0);
        xact(1'b1, 32'h8, 4'h5, 32'h11223344, rd, er);
        chk("wr2_old", rd, 32'hDEADBEEF);
        xact(1'b0, 32'h8, 4'h0, 32'h0, rd, er);
        chk("wr_merge", rd, 32'hDE22BE44);
        xact(1'b1, 32'h0, 4'hF, 32'h01010101, rd, er);
        xact(1'b1, 32'h4, 4'hF, 32'h02020202, rd, er);

        // Back-to-back reads with resp_ready high.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = i * 4;
            chk("b2b_ready", {31'd0, bus.req_ready}, 32'd1);
            @(posedge clk);
            #1;
            chk("b2b_valid", {31'd0, bus.resp_valid}, 32'd1);
            case (i)
                0: chk("b2b_rd0", bus.resp_rdata, 32'h01010101);
                1: chk("b2b_rd1", bus.resp_rdata, 32'h02020202);
                default: chk("b2b_rd2", bus.resp_rdata, 32'hDE22BE44);
            endcase
        end
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_drain", {31'd0, bus.resp_valid}, 32'd0);

        // Backpressure: response held, queued request waits.
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h4;
        @(posedge clk);
        #1;
        chk("bp_valid", {31'd0, bus.resp_valid}, 32'd1);
        bus.req_addr = 32'h8;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready0", {31'd0, bus.req_ready}, 32'd0);
            chk("bp_hold", bus.resp_rdata, 32'h02020202);
            chk("bp_vhold", {31'd0, bus.resp_valid}, 32'd1);
        end
        bus.resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("bp_next_valid", {31'd0, bus.resp_valid}, 32'd1);
        chk("bp_next_rd", bus.resp_rdata, 32'hDE22BE44);
        @(posedge clk);
        #1;
        chk("bp_drain", {31'd0, bus.resp_valid}, 32'd0);

        // Misaligned and out-of-range requests are rejected.
        xact(1'b1, 32'h2, 4'hF, 32'hFFFFFFFF, rd, er);
        chk("err_mis_flag", {31'd0, er}, 32'd1);
        chk("err_mis_rd", rd, 32'h0);
        xact(1'b1, 32'h40, 4'hF, 32'hFFFFFFFF, rd, er);
        chk("err_oor_flag", {31'd0, er}, 32'd1);
        chk("err_oor_rd", rd, 32'h0);
        xact(1'b0, 32'h0, 4'h0, 32'h0, rd, er);
        chk("err_mem_rd", rd, 32'h01010101);
        chk("err_mem_err", {31'd0, er}, 32'd0);

        // Reset in the middle of a held response.
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h4;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("mid_resp_pre", {31'd0, bus.resp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_resp");
        bus.resp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of the scrub.
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_scrub");
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(n, rdy_seen);
        chk("rescrub_edges", n, 32'd16);
        chk("rescrub_ready0", {31'd0, rdy_seen}, 32'd0);
        xact(1'b0, 32'h4, 4'h0, 32'h0, rd, er);
        chk("rescrub_rd", rd, 32'h0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
